// File: rtl/bcd_stopwatch_core_pkg.sv
// Shared BCD definitions for the stopwatch core: digit type, digit constants
// and elaboration-time helpers used to size and compare multi-digit values.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO   = 4'h0;
  localparam bcd_digit_t BCD_NINE   = 4'h9;
  localparam int         MAX_DIGITS = 8;
  localparam int         PAD_W      = 4 * MAX_DIGITS;

  function automatic int clog2(input int value);
    int r;
    int p;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      p = 32'sd1 <<< i;
      if (p < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // True when the low n digits of value all equal d.
  function automatic logic bcd_all_eq(input logic [PAD_W-1:0] value, input int n, input bcd_digit_t d);
    logic eq;
    eq = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < n) begin
        eq = eq & (value[4*k +: 4] == d);
      end else begin
        eq = eq;
      end
    end
    return eq;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// Control and status bundle between the stopwatch core and its board-level user.
interface bcd_stopwatch_core_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    clear;
  logic                    start_stop;
  logic                    lap;
  logic                    down;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    running;
  logic                    lap_active;
  logic                    tick;
  logic                    overflow;

  modport master (
    output clear, start_stop, lap, down,
    input  count_bcd, disp_bcd, running, lap_active, tick, overflow
  );

  modport slave (
    input  clear, start_stop, lap, down,
    output count_bcd, disp_bcd, running, lap_active, tick, overflow
  );

endinterface

// File: rtl/bcd_stopwatch_core_digit_cell.sv
// One BCD digit of the stopwatch ripple chain: +/-1 when cin is set, with carry/borrow out.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       cin,
  input  logic       down,
  output bcd_digit_t digit_next,
  output logic       cout
);

  // Step the digit; codes above 9 recover to 0 (up, with carry) or 8 (down).
  always_comb begin
    digit_next = digit;
    cout       = 1'b0;
    if (!cin) begin
      digit_next = digit;
      cout       = 1'b0;
    end else if (!down) begin
      if (digit >= BCD_NINE) begin
        digit_next = BCD_ZERO;
        cout       = 1'b1;
      end else begin
        digit_next = digit + 4'd1;
        cout       = 1'b0;
      end
    end else begin
      if (digit == BCD_ZERO) begin
        digit_next = BCD_NINE;
        cout       = 1'b1;
      end else if (digit > BCD_NINE) begin
        digit_next = 4'h8;
        cout       = 1'b0;
      end else begin
        digit_next = digit - 4'd1;
        cout       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch: prescaled tick, run/pause, up/down, wrap or saturate,
// and a lap register that freezes the displayed value.
module bcd_stopwatch_core
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 500000,
  parameter bit WRAP       = 1'b1
) (
  input logic                 CLOCK_50,
  input logic                 resetn,
  bcd_stopwatch_core_if.slave sw
);

  localparam int            PW         = clog2(TICK_DIV);
  localparam int            CW         = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(32'd1);

  logic [PW-1:0]       presc_r, presc_nxt_s;
  logic [CW-1:0]       count_r, count_nxt_s, lap_r, lap_nxt_s, stepped_s;
  logic                running_r, running_nxt_s;
  logic                lap_active_r, lap_active_nxt_s;
  logic                tick_r, tick_nxt_s;
  logic                overflow_r, overflow_nxt_s;
  logic [NUM_DIGITS:0] carry_s;
  logic                term_cyc_s, at_term_s, lands_s, step_en_s, sat_stop_s;
  bcd_digit_t          term_digit_s;

  assign term_cyc_s   = running_r && (presc_r == PRESC_LAST);
  assign term_digit_s = sw.down ? BCD_ZERO : BCD_NINE;
  assign at_term_s    = bcd_all_eq(PAD_W'(count_r), NUM_DIGITS, term_digit_s);
  assign lands_s      = bcd_all_eq(PAD_W'(stepped_s), NUM_DIGITS, term_digit_s);
  // A saturated counter sitting on its terminal value must not move again.
  assign step_en_s    = term_cyc_s && !sw.clear && (WRAP || !at_term_s);

  assign carry_s[0] = step_en_s;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (count_r[4*k +: 4]),
      .cin        (carry_s[k]),
      .down       (sw.down),
      .digit_next (stepped_s[4*k +: 4]),
      .cout       (carry_s[k+1])
    );
  end

  // Next-state logic: clear dominates, then prescaler/step, lap toggle, run control.
  always_comb begin
    presc_nxt_s      = presc_r;
    count_nxt_s      = count_r;
    lap_nxt_s        = lap_r;
    lap_active_nxt_s = lap_active_r;
    running_nxt_s    = running_r;
    tick_nxt_s       = 1'b0;
    overflow_nxt_s   = 1'b0;
    sat_stop_s       = 1'b0;
    if (sw.clear) begin
      presc_nxt_s      = {PW{1'b0}};
      count_nxt_s      = {CW{1'b0}};
      lap_nxt_s        = {CW{1'b0}};
      lap_active_nxt_s = 1'b0;
    end else begin
      if (term_cyc_s) begin
        presc_nxt_s = {PW{1'b0}};
        if (!WRAP && at_term_s) begin
          overflow_nxt_s = 1'b1;
          sat_stop_s     = 1'b1;
        end else begin
          count_nxt_s    = stepped_s;
          tick_nxt_s     = 1'b1;
          overflow_nxt_s = WRAP ? carry_s[NUM_DIGITS] : lands_s;
          sat_stop_s     = !WRAP && lands_s;
        end
      end else if (running_r) begin
        presc_nxt_s = presc_r + PRESC_ONE;
      end else begin
        presc_nxt_s = presc_r;
      end

      // Lap captures the pre-step count so a coincident tick is not shown early.
      if (sw.lap) begin
        lap_active_nxt_s = !lap_active_r;
        lap_nxt_s        = lap_active_r ? lap_r : count_r;
      end else begin
        lap_active_nxt_s = lap_active_r;
        lap_nxt_s        = lap_r;
      end

      if (sat_stop_s) begin
        running_nxt_s = 1'b0;
      end else if (sw.start_stop) begin
        running_nxt_s = !running_r;
      end else begin
        running_nxt_s = running_r;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      presc_r      <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      lap_r        <= {CW{1'b0}};
      lap_active_r <= 1'b0;
      running_r    <= 1'b0;
      tick_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      presc_r      <= presc_nxt_s;
      count_r      <= count_nxt_s;
      lap_r        <= lap_nxt_s;
      lap_active_r <= lap_active_nxt_s;
      running_r    <= running_nxt_s;
      tick_r       <= tick_nxt_s;
      overflow_r   <= overflow_nxt_s;
    end
  end

  assign sw.count_bcd  = count_r;
  assign sw.disp_bcd   = lap_active_r ? lap_r : count_r;
  assign sw.running    = running_r;
  assign sw.lap_active = lap_active_r;
  assign sw.tick       = tick_r;
  assign sw.overflow   = overflow_r;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core: a wrapping and a saturating instance, an integer
// stopwatch model checked every cycle, plus directed literal checkpoints.
module tb_bcd_stopwatch_core;

  localparam int ND = 2;
  localparam int TD = 4;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b1;
  int   total    = 0;
  int   bad      = 0;
  bit   chk_en   = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  bcd_stopwatch_core_if #(.NUM_DIGITS(ND)) if_w ();
  bcd_stopwatch_core_if #(.NUM_DIGITS(ND)) if_s ();

  bcd_stopwatch_core #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(1'b1)) dut_w (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .sw       (if_w)
  );

  bcd_stopwatch_core #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(1'b0)) dut_s (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .sw       (if_s)
  );

  logic [7:0] d_cnt [2];
  logic [7:0] d_disp[2];
  logic       d_run [2];
  logic       d_lact[2];
  logic       d_tick[2];
  logic       d_ovf [2];

  assign d_cnt[0]  = if_w.count_bcd;
  assign d_disp[0] = if_w.disp_bcd;
  assign d_run[0]  = if_w.running;
  assign d_lact[0] = if_w.lap_active;
  assign d_tick[0] = if_w.tick;
  assign d_ovf[0]  = if_w.overflow;
  assign d_cnt[1]  = if_s.count_bcd;
  assign d_disp[1] = if_s.disp_bcd;
  assign d_run[1]  = if_s.running;
  assign d_lact[1] = if_s.lap_active;
  assign d_tick[1] = if_s.tick;
  assign d_ovf[1]  = if_s.overflow;

  // Model state: count as a plain integer 0..99, index 0 = wrapping, 1 = saturating.
  int m_cnt  [2] = '{0, 0};
  int m_presc[2] = '{0, 0};
  int m_lap  [2] = '{0, 0};
  bit m_run  [2] = '{1'b0, 1'b0};
  bit m_lact [2] = '{1'b0, 1'b0};
  bit m_tick [2] = '{1'b0, 1'b0};
  bit m_ovf  [2] = '{1'b0, 1'b0};

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_cnt[i] = 0; m_presc[i] = 0; m_lap[i] = 0;
    m_run[i] = 1'b0; m_lact[i] = 1'b0; m_tick[i] = 1'b0; m_ovf[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input bit wrap, input bit clr, input bit ss,
                            input bit lp, input bit dn);
    int  old, term;
    bit  stop;
    old  = m_cnt[i];
    term = dn ? 0 : 99;
    stop = 1'b0;
    m_tick[i] = 1'b0;
    m_ovf[i]  = 1'b0;
    if (clr) begin
      m_cnt[i] = 0; m_presc[i] = 0; m_lap[i] = 0; m_lact[i] = 1'b0;
    end else begin
      if (m_run[i] && m_presc[i] == TD - 1) begin
        m_presc[i] = 0;
        if (!wrap && old == term) begin
          m_ovf[i] = 1'b1;
          stop     = 1'b1;
        end else begin
          m_tick[i] = 1'b1;
          m_cnt[i]  = (old + (dn ? 99 : 1)) % 100;
          if (wrap && old == term) m_ovf[i] = 1'b1;
          if (!wrap && m_cnt[i] == term) begin
            m_ovf[i] = 1'b1;
            stop     = 1'b1;
          end
        end
      end else if (m_run[i]) begin
        m_presc[i]++;
      end
      if (lp) begin
        if (!m_lact[i]) m_lap[i] = old;
        m_lact[i] = !m_lact[i];
      end
      if (stop) m_run[i] = 1'b0;
      else if (ss) m_run[i] = !m_run[i];
    end
  endtask

  initial begin
    forever begin
      @(posedge CLOCK_50 or negedge resetn);
      if (!resetn) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, 1'b1, if_w.clear, if_w.start_stop, if_w.lap, if_w.down);
        model_step(1, 1'b0, if_s.clear, if_s.start_stop, if_s.lap, if_s.down);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("cnt%0d", i),  d_cnt[i],  to_bcd(m_cnt[i]));
          chk($sformatf("disp%0d", i), d_disp[i], m_lact[i] ? to_bcd(m_lap[i]) : to_bcd(m_cnt[i]));
          chk($sformatf("run%0d", i),  d_run[i],  m_run[i]);
          chk($sformatf("lact%0d", i), d_lact[i], m_lact[i]);
          chk($sformatf("tick%0d", i), d_tick[i], m_tick[i]);
          chk($sformatf("ovf%0d", i),  d_ovf[i],  m_ovf[i]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic pulse_ss(input logic [1:0] m);
    if_w.start_stop = m[0]; if_s.start_stop = m[1];
    cyc(1);
    if_w.start_stop = 1'b0; if_s.start_stop = 1'b0;
  endtask

  task automatic pulse_lap(input logic [1:0] m);
    if_w.lap = m[0]; if_s.lap = m[1];
    cyc(1);
    if_w.lap = 1'b0; if_s.lap = 1'b0;
  endtask

  task automatic pulse_clr(input logic [1:0] m);
    if_w.clear = m[0]; if_s.clear = m[1];
    cyc(1);
    if_w.clear = 1'b0; if_s.clear = 1'b0;
  endtask

  logic [7:0] up_exp [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};
  logic [7:0] dn_exp [10] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  initial begin
    if_w.clear = 1'b0; if_w.start_stop = 1'b0; if_w.lap = 1'b0; if_w.down = 1'b0;
    if_s.clear = 1'b0; if_s.start_stop = 1'b0; if_s.lap = 1'b0; if_s.down = 1'b0;
    #1 resetn = 1'b0;
    #1 chk_en = 1'b1;
    cyc(3);
    chk("rst_cnt", if_w.count_bcd, 8'h00);
    chk("rst_run", if_w.running, 1'b0);
    chk("rst_tick", if_w.tick, 1'b0);
    resetn = 1'b1;

    // Count up 00..10 on both instances, one tick every TD cycles.
    pulse_ss(2'b11);
    for (int k = 0; k < 10; k++) begin
      cyc(4);
      chk("up_cnt", if_w.count_bcd, up_exp[k]);
      chk("up_tick", if_w.tick, 1'b1);
    end

    // Up to 99: saturating instance stops, wrapping one rolls to 00 next tick.
    cyc(356);
    chk("w99_cnt", if_w.count_bcd, 8'h99);
    chk("w99_ovf", if_w.overflow, 1'b0);
    chk("s99_cnt", if_s.count_bcd, 8'h99);
    chk("s99_ovf", if_s.overflow, 1'b1);
    chk("s99_run", if_s.running, 1'b0);
    cyc(1);
    chk("s99_ovf_drop", if_s.overflow, 1'b0);
    cyc(3);
    chk("wrap_cnt", if_w.count_bcd, 8'h00);
    chk("wrap_ovf", if_w.overflow, 1'b1);
    chk("wrap_run", if_w.running, 1'b1);
    cyc(1);
    chk("wrap_ovf_drop", if_w.overflow, 1'b0);

    // Saturating down count from 10 to 00, then a restart while at terminal.
    pulse_clr(2'b10);
    pulse_ss(2'b10);
    cyc(40);
    chk("s_at10", if_s.count_bcd, 8'h10);
    if_s.down = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(4);
      chk("dn_cnt", if_s.count_bcd, dn_exp[k]);
    end
    chk("dn_ovf", if_s.overflow, 1'b1);
    chk("dn_run", if_s.running, 1'b0);
    cyc(20);
    chk("dn_hold", if_s.count_bcd, 8'h00);
    pulse_ss(2'b10);
    cyc(3);
    chk("term_start_run", if_s.running, 1'b1);
    cyc(1);
    chk("term_start_ovf", if_s.overflow, 1'b1);
    chk("term_start_stop", if_s.running, 1'b0);
    chk("term_start_tick", if_s.tick, 1'b0);

    // Lap freeze at 23 while counting on to 31, then release.
    pulse_clr(2'b01);
    cyc(92);
    chk("lap_at23", if_w.count_bcd, 8'h23);
    pulse_lap(2'b01);
    cyc(31);
    chk("lap_cnt", if_w.count_bcd, 8'h31);
    chk("lap_disp", if_w.disp_bcd, 8'h23);
    chk("lap_act", if_w.lap_active, 1'b1);
    pulse_lap(2'b01);
    chk("lap_release", if_w.disp_bcd, 8'h31);

    // Clear coinciding with a prescaler terminal and a start_stop pulse.
    pulse_lap(2'b01);
    cyc(1);
    if_w.clear = 1'b1; if_w.start_stop = 1'b1;
    cyc(1);
    if_w.clear = 1'b0; if_w.start_stop = 1'b0;
    chk("clr_cnt", if_w.count_bcd, 8'h00);
    chk("clr_tick", if_w.tick, 1'b0);
    chk("clr_run", if_w.running, 1'b1);
    chk("clr_lact", if_w.lap_active, 1'b0);

    // Asynchronous reset mid-prescale at 57.
    cyc(228);
    chk("at57", if_w.count_bcd, 8'h57);
    cyc(1);
    resetn = 1'b0;
    #1;
    chk("arst_cnt", if_w.count_bcd, 8'h00);
    chk("arst_run", if_w.running, 1'b0);
    chk("arst_disp", if_w.disp_bcd, 8'h00);
    cyc(1);
    resetn = 1'b1;
    cyc(8);
    chk("post_rst_idle", if_w.count_bcd, 8'h00);
    pulse_ss(2'b01);
    cyc(3);
    chk("post_rst_early", if_w.tick, 1'b0);
    cyc(1);
    chk("post_rst_tick", if_w.tick, 1'b1);
    chk("post_rst_cnt", if_w.count_bcd, 8'h01);

    // Wrapping down count: 01 -> 00 quietly, then 00 -> 99 with overflow.
    if_w.down = 1'b1;
    cyc(4);
    chk("wdn_00", if_w.count_bcd, 8'h00);
    chk("wdn_00_ovf", if_w.overflow, 1'b0);
    cyc(4);
    chk("wdn_99", if_w.count_bcd, 8'h99);
    chk("wdn_99_ovf", if_w.overflow, 1'b1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
